// File: rtl/rijndael_mask_seq.sv
// rijndael_mask_seq: sequencer feeding one byte pair with fresh LFSR masks to a masked S-box core and returning S(pt^key).
// Defining RIJNDAEL_SEQ_UNMASKED_EN forces both masks to zero and freezes the LFSR.
module rijndael_mask_seq #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  pt,
  input  logic [7:0]  key,
  output logic        core_valid,
  output logic [7:0]  core_din,
  output logic [7:0]  core_key,
  output logic [7:0]  core_imask,
  output logic [7:0]  core_omask,
  input  logic [7:0]  core_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  ct,
  output logic        trigger,
  output logic [15:0] op_count
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, OUT} state_t;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  state_t      state_q, state_d;
  logic [7:0]  din_q, din_d, key_q, key_d, imask_q, imask_d, omask_q, omask_d, ct_q, ct_d;
  logic [15:0] lfsr_q, lfsr_d, cnt_q, cnt_d;
  logic        trig_q, trig_d, accept;
`ifndef RIJNDAEL_SEQ_UNMASKED_EN
  logic [15:0] lfsr_step;
`endif
  always_comb begin
    accept = (state_q == IDLE) && in_valid;
    case (state_q)
      IDLE:    state_d = in_valid ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = CAPTURE;
      CAPTURE: state_d = OUT;
      OUT:     state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
    din_d  = accept ? pt : din_q;
    key_d  = accept ? key : key_q;
`ifdef RIJNDAEL_SEQ_UNMASKED_EN
    imask_d = 8'h00;
    omask_d = 8'h00;
    lfsr_d  = lfsr_q;
`else
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    imask_d   = accept ? lfsr_q[7:0] : imask_q;
    omask_d   = accept ? lfsr_q[15:8] : omask_q;
    lfsr_d    = accept ? lfsr_step : lfsr_q;
`endif
    // Core unmasks with the live omask, so the result is only valid while masks are still held
    ct_d   = (state_q == CAPTURE) ? core_dout : ct_q;
    cnt_d  = (state_q == CAPTURE) ? cnt_q + 16'd1 : cnt_q;
    trig_d = (state_d == ISSUE) || (state_d == WAIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= 8'h00;
      key_q   <= 8'h00;
      imask_q <= 8'h00;
      omask_q <= 8'h00;
      ct_q    <= 8'h00;
      lfsr_q  <= SEED;
      cnt_q   <= 16'h0000;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      key_q   <= key_d;
      imask_q <= imask_d;
      omask_q <= omask_d;
      ct_q    <= ct_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
    end
  end
  assign in_ready   = (state_q == IDLE);
  assign core_valid = (state_q == ISSUE);
  assign out_valid  = (state_q == OUT);
  assign core_din   = din_q;
  assign core_key   = key_q;
  assign core_imask = imask_q;
  assign core_omask = omask_q;
  assign ct         = ct_q;
  assign trigger    = trig_q;
  assign op_count   = cnt_q;
endmodule
